// File: rtl/pe_dbuf.sv
// pe_dbuf: systolic-array processing element with a double-buffered weight register.
//
// Weight-stationary (mode=0): each valid activation is multiplied by the active weight and
// added to the partial sum coming from above; the result moves down one row per cycle.
// Output-stationary (mode=1): products accumulate locally; a drain pulse emits the
// accumulator, and other cycles forward sum_in so drained values ripple down the column.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   enable                          global stall (low = all registers hold)
//   mode                            0 = WS, 1 = OS
//   weight_in/weight_load           shadow weight chain input and shift strobe
//   weight_swap                     copy shadow weight into the active weight
//   activ_in/activ_valid_in         activation from the left and its qualifier
//   sum_in/sum_valid_in             partial sum / drained value from above and qualifier
//   acc_clear, drain                OS accumulator controls
//   weight_out/weight_load_out      shadow weight and registered strobe, to PE below
//   activ_out/activ_valid_out       registered activation, to PE on the right
//   sum_out/sum_valid_out           result to PE below and its qualifier
//   ovf                             sticky overflow flag
//
// Build option: define PE_SAT_EN for saturating additions with a sticky ovf flag.
// Without it, additions wrap modulo 2^result_width and ovf is constant 0.

module pe_dbuf #(
  parameter int unsigned data_width   = 8,
  parameter int unsigned result_width = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [data_width-1:0]   weight_in,
  input  logic                    weight_load,
  input  logic                    weight_swap,
  input  logic [data_width-1:0]   activ_in,
  input  logic                    activ_valid_in,
  input  logic [result_width-1:0] sum_in,
  input  logic                    sum_valid_in,
  input  logic                    acc_clear,
  input  logic                    drain,
  output logic [data_width-1:0]   weight_out,
  output logic                    weight_load_out,
  output logic [data_width-1:0]   activ_out,
  output logic                    activ_valid_out,
  output logic [result_width-1:0] sum_out,
  output logic                    sum_valid_out,
  output logic                    ovf
);

  localparam int unsigned ProdWidth = 2 * data_width;

  logic [data_width-1:0]   r_shadow;
  logic [data_width-1:0]   r_active;
  logic [result_width-1:0] r_acc;
  logic                    r_last_mode;
  logic                    r_wload_out;
  logic [data_width-1:0]   r_activ_out;
  logic                    r_activ_valid_out;
  logic [result_width-1:0] r_sum_out;
  logic                    r_sum_valid_out;

  logic signed [ProdWidth-1:0]    w_op_a;
  logic signed [ProdWidth-1:0]    w_op_b;
  logic signed [ProdWidth-1:0]    w_prod_raw;
  logic signed [result_width-1:0] w_prod;
  logic [result_width-1:0]        w_sum_in_q;
  logic [result_width-1:0]        w_ws_sum;
  logic [result_width-1:0]        w_acc_sum;
  logic                           w_mode_chg;

  // Operands are sign-extended first so the product is exact in ProdWidth bits.
  assign w_op_a     = ProdWidth'($signed(activ_in));
  assign w_op_b     = ProdWidth'($signed(r_active));
  assign w_prod_raw = w_op_a * w_op_b;
  assign w_prod     = activ_valid_in ? result_width'(w_prod_raw) : '0;
  assign w_sum_in_q = sum_valid_in ? sum_in : '0;
  assign w_mode_chg = (mode != r_last_mode);

`ifdef PE_SAT_EN
  localparam logic [result_width-1:0] SatMax = {1'b0, {(result_width-1){1'b1}}};
  localparam logic [result_width-1:0] SatMin = {1'b1, {(result_width-1){1'b0}}};

  logic [result_width:0] w_ws_wide;
  logic [result_width:0] w_acc_wide;
  logic                  w_ws_clamp;
  logic                  w_acc_clamp;
  logic                  r_ovf;

  // One guard bit: the add overflowed when the guard and sign bits disagree.
  assign w_ws_wide   = {w_sum_in_q[result_width-1], w_sum_in_q} +
                       {w_prod[result_width-1], w_prod};
  assign w_acc_wide  = {r_acc[result_width-1], r_acc} + {w_prod[result_width-1], w_prod};
  assign w_ws_clamp  = w_ws_wide[result_width] ^ w_ws_wide[result_width-1];
  assign w_acc_clamp = w_acc_wide[result_width] ^ w_acc_wide[result_width-1];
  assign w_ws_sum    = w_ws_clamp ? (w_ws_wide[result_width] ? SatMin : SatMax)
                                  : w_ws_wide[result_width-1:0];
  assign w_acc_sum   = w_acc_clamp ? (w_acc_wide[result_width] ? SatMin : SatMax)
                                   : w_acc_wide[result_width-1:0];

  // Flag only clamps whose result is actually committed this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (enable) begin
      if (!mode && w_ws_clamp) begin
        r_ovf <= 1'b1;
      end else if (mode && !w_mode_chg && (drain || !acc_clear) && w_acc_clamp) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ovf = r_ovf;
`else
  assign w_ws_sum  = w_sum_in_q + w_prod;
  assign w_acc_sum = r_acc + w_prod;
  assign ovf       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow          <= '0;
      r_active          <= '0;
      r_acc             <= '0;
      r_last_mode       <= 1'b0;
      r_wload_out       <= 1'b0;
      r_activ_out       <= '0;
      r_activ_valid_out <= 1'b0;
      r_sum_out         <= '0;
      r_sum_valid_out   <= 1'b0;
    end else if (enable) begin
      r_wload_out <= weight_load;
      if (weight_load) begin
        r_shadow <= weight_in;
      end
      // Non-blocking: a simultaneous load leaves the old shadow in the active weight.
      if (weight_swap) begin
        r_active <= r_shadow;
      end
      r_activ_out       <= activ_in;
      r_activ_valid_out <= activ_valid_in;
      r_last_mode       <= mode;

      if (!mode) begin
        r_sum_out       <= w_ws_sum;
        r_sum_valid_out <= activ_valid_in;
        if (w_mode_chg) begin
          r_acc <= '0;
        end
      end else if (w_mode_chg) begin
        // Entering OS: start from a clean accumulator, ignore this cycle's drain/MAC.
        r_acc           <= '0;
        r_sum_out       <= sum_in;
        r_sum_valid_out <= sum_valid_in;
      end else if (drain) begin
        r_sum_out       <= w_acc_sum;
        r_sum_valid_out <= 1'b1;
        r_acc           <= '0;
      end else begin
        r_sum_out       <= sum_in;
        r_sum_valid_out <= sum_valid_in;
        if (acc_clear) begin
          r_acc <= w_prod;
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

  assign weight_out      = r_shadow;
  assign weight_load_out = r_wload_out;
  assign activ_out       = r_activ_out;
  assign activ_valid_out = r_activ_valid_out;
  assign sum_out         = r_sum_out;
  assign sum_valid_out   = r_sum_valid_out;

endmodule
